// File: rtl/qam_pkg.sv
// Shared types and the symbol-to-level mapping used by the QAM mapper.
// Levels are at 8-bit scale; the top level widens them to the output width.
package qam_pkg;

    typedef enum logic [1:0] {
        QPSK  = 2'd0,
        QAM16 = 2'd1,
        QAM64 = 2'd2,
        RSVD  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] MAG_QPSK      = 8'd45;
    localparam logic [7:0] MAG16_INNER   = 8'd20;
    localparam logic [7:0] MAG16_OUTER   = 8'd61;
    localparam logic [7:0] MAG64_IDX3    = 8'd9;
    localparam logic [7:0] MAG64_IDX2    = 8'd28;
    localparam logic [7:0] MAG64_IDX0    = 8'd47;
    localparam logic [7:0] MAG64_IDX1    = 8'd66;

    typedef struct packed {
        logic [7:0] i;
        logic [7:0] q;
    } iq8_t;

    // Axis bit0 is the sign (1 = positive); the bits above it are a Gray-coded magnitude index.
    function automatic logic [7:0] axis_level(input mode_t m, input logic [2:0] b);
        logic [7:0] mag;
        mag = '0;
        case (m)
            QPSK:  mag = MAG_QPSK;
            QAM16: mag = b[1] ? MAG16_INNER : MAG16_OUTER;
            QAM64: begin
                case (b[2:1])
                    2'b11:   mag = MAG64_IDX3;
                    2'b10:   mag = MAG64_IDX2;
                    2'b00:   mag = MAG64_IDX0;
                    default: mag = MAG64_IDX1;
                endcase
            end
            default: mag = '0;
        endcase
        return b[0] ? mag : ((~mag) + 8'd1);
    endfunction

    function automatic iq8_t qam_map(input mode_t m, input logic [5:0] sym);
        iq8_t r;
        r = '0;
        case (m)
            QPSK: begin
                r.i = axis_level(m, {2'b00, sym[1]});
                r.q = axis_level(m, {2'b00, sym[0]});
            end
            QAM16: begin
                r.i = axis_level(m, {1'b0, sym[3:2]});
                r.q = axis_level(m, {1'b0, sym[1:0]});
            end
            QAM64: begin
                r.i = axis_level(m, sym[5:3]);
                r.q = axis_level(m, sym[2:0]);
            end
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/qam_mapper_multi_fifo.sv
// Synchronous symbol FIFO; a pushed entry becomes readable (rd_vld) one cycle after the push.
// Latency: push at edge N, readable after edge N+1; full counts every stored entry.
// Backpressure: push is dropped while full; pop is honoured only while rd_vld.
module qam_sym_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             rd_vld
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      wr_ptr_seen;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    // The read side trails the write pointer by a cycle, giving the mapper its extra stage.
    assign rd_vld  = (wr_ptr_seen != rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && rd_vld;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            wr_ptr_seen <= '0;
            rd_ptr      <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            wr_ptr_seen <= wr_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/qam_mapper_multi.sv
// Per-frame QPSK/16-QAM/64-QAM mapper with input FIFO and a registered I/Q output stage.
// Latency: symbol accepted at edge N is presented after edge N+2; 1 symbol/cycle sustained.
// Backpressure: output holds while data_valid_o & !data_ready_i; data_ready_o drops when FIFO full.
module qam_mapper_multi #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [5:0]        symbol,
    input  logic              data_valid_i,
    output logic              data_ready_o,
    input  logic              done_flag_i,
    output logic [DATA_W-1:0] I_data,
    output logic [DATA_W-1:0] Q_data,
    output logic              data_valid_o,
    input  logic              data_ready_i,
    output logic              done_flag_o,
    output logic              mode_err_o
);
    import qam_pkg::*;

    state_t            state;
    mode_t             mode_q;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_rd_vld;
    logic [5:0]        fifo_dout;
    logic              push;
    logic              out_load;
    logic              out_free;
    iq8_t              iq;
    logic [DATA_W-1:0] i_scaled;
    logic [DATA_W-1:0] q_scaled;

    assign data_ready_o = (state == RUN) && !fifo_full;
    assign push         = data_valid_i && data_ready_o;
    assign out_free     = !data_valid_o || data_ready_i;
    assign out_load     = fifo_rd_vld && out_free;

    qam_sym_fifo #(
        .WIDTH (6),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .din    (symbol),
        .pop    (out_load),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .rd_vld (fifo_rd_vld)
    );

    // Mapping uses the frame's latched mode, so FIFO contents never see a mid-frame change.
    assign iq       = qam_map(mode_q, fifo_dout);
    assign i_scaled = DATA_W'($signed(iq.i)) << (DATA_W - 8);
    assign q_scaled = DATA_W'($signed(iq.q)) << (DATA_W - 8);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            mode_q      <= QPSK;
            done_flag_o <= 1'b0;
            mode_err_o  <= 1'b0;
        end else begin
            done_flag_o <= 1'b0;
            mode_err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (mode_t'(mode) == RSVD) begin
                            mode_err_o <= 1'b1;
                        end else begin
                            mode_q <= mode_t'(mode);
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (done_flag_i) state <= DRAIN;
                end
                DRAIN: begin
                    if (fifo_empty && out_free) begin
                        state       <= DONE;
                        done_flag_o <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            I_data       <= '0;
            Q_data       <= '0;
            data_valid_o <= 1'b0;
        end else if (out_load) begin
            I_data       <= i_scaled;
            Q_data       <= q_scaled;
            data_valid_o <= 1'b1;
        end else if (data_ready_i) begin
            data_valid_o <= 1'b0;
        end
    end

endmodule
